// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format constants and the serializer state
// encoding, common to the transmit path and any receiver reusing bit timing.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_STOP_BITS  = 1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (control only)
//   wr_en, wr_data   write request and data; ignored while full
//   rd_en, rd_data   pop request; rd_data shows the head whenever not empty
//   full, empty      registered occupancy flags
//   count            number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    // Flags are registered, so a pop in this cycle never frees a slot for a
    // write in the same cycle.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok)
            count_nxt = count + CW'(1);
        else if (rd_ok && !wr_ok)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: queues strobed bytes and serializes them
// LSB first, back to back when the queue stays non-empty.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   transmit, tx_byte one-cycle enqueue request and its byte
//   tx                registered serial line, idles high
//   is_transmitting   frame on the line or bytes waiting
//   fifo_full/empty   queue occupancy flags
//   overflow          one-cycle pulse when a request hit a full queue
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 12000000,
    parameter int fifo_depth   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       is_transmitting,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;
    localparam int BCNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W        = $clog2(fifo_depth) + 1;

    uart_state_t       state;
    logic [BCNT_W-1:0] bcnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [7:0]        head;
    logic [CNT_W-1:0]  fifo_count;
    logic              bit_done;
    logic              pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (transmit),
        .wr_data (tx_byte),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_done = (bcnt == BCNT_W'(CLKS_PER_BIT - 1));

    // Pop from IDLE, or at the last stop cycle so the next start bit follows
    // without an idle gap.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && bit_done));

    always_ff @(posedge clk) begin
        if (pop)
            shift <= head;
        else if ((state == DATA) && bit_done)
            shift <= {1'b0, shift[7:1]};
    end

    // tx is registered from the current state, so it trails the state by one
    // cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bcnt            <= '0;
            bit_idx         <= '0;
            tx              <= UART_IDLE_LEVEL;
            is_transmitting <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            overflow        <= transmit && fifo_full;
            // fifo_count is zero exactly when fifo_empty is set.
            is_transmitting <= (state != IDLE) || (fifo_count != '0);

            unique case (state)
                IDLE:  tx <= UART_IDLE_LEVEL;
                START: tx <= 1'b0;
                DATA:  tx <= shift[0];
                STOP:  tx <= UART_IDLE_LEVEL;
                default: tx <= UART_IDLE_LEVEL;
            endcase

            if (state == IDLE || bit_done)
                bcnt <= '0;
            else
                bcnt <= bcnt + BCNT_W'(1);

            unique case (state)
                IDLE: begin
                    if (!fifo_empty)
                        state <= START;
                end
                START: begin
                    if (bit_done) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'(UART_DATA_BITS - 1))
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (bit_done)
                        state <= fifo_empty ? IDLE : START;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter. It is the transmit end of the byte-echo path: the receive side hands bytes in with a one-cycle strobe, and this block queues them and serializes them onto the TTL Tx line.
- It replaces bare single-byte transmission. Bursts of received or debug bytes are no longer lost while a frame is in flight.
- It sits between debugger response logic (or the receive strobe) and the RS232_Tx_TTL pad.

Parameters:
- baud_rate, 9600, line bit rate in bits/s.
- sys_clk_freq, 12000000, clk frequency in Hz.
- fifo_depth, 16, byte entries in the queue. Must be a power of two, 2..256.
- Derived localparam CLKS_PER_BIT = sys_clk_freq / baud_rate, truncated. Must be at least 2.

Ports:
- clk  input  1  master clock; all logic is clocked on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- transmit  input  1  one-cycle request to enqueue tx_byte.
- tx_byte  input  8  byte to enqueue; sampled when transmit is high.
- tx  output  1  serial line; idles high.
- is_transmitting  output  1  high while a frame is on the line or the queue is non-empty.
- fifo_full  output  1  queue holds fifo_depth entries.
- fifo_empty  output  1  queue holds 0 entries.
- overflow  output  1  one-cycle pulse: a transmit request was dropped because the queue was full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: tx=1, is_transmitting=0, fifo_full=0, fifo_empty=1, overflow=0.
  - Internal: pointers, count, baud counter and bit index cleared; state IDLE.
- Reset mid-frame aborts the frame: tx returns high immediately, and queued data is discarded.
- Enqueue:
  - At a rising edge with transmit=1 and fifo_full=0, tx_byte is written and count increments.
  - With transmit=1 and fifo_full=1, the byte is dropped and overflow=1 for the next cycle only.
  - The full flag is registered, so a pop in the same cycle does not make room for a write.
- Write and pop in the same cycle: count is unchanged, and both the write and the pop take effect.
- Pointers are log2(fifo_depth) bits and wrap modulo fifo_depth. Count is log2(fifo_depth)+1 bits.
- Serializer state machine, with baud counter bcnt from 0 to CLKS_PER_BIT-1:
  - IDLE: tx=1. If fifo_empty=0, pop the head into an 8-bit shift register, clear bcnt and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last STOP cycle:
    - if the queue is non-empty, pop and go directly to START, giving back-to-back frames with no idle gap;
    - otherwise go to IDLE.
- tx is driven from a register, so it is glitch-free.
- Latency: a byte accepted at edge N into an empty queue with IDLE state gives tx=0 from edge N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles; consecutive queued frames start 10*CLKS_PER_BIT apart.
- is_transmitting = (state != IDLE) or (fifo_empty = 0). It stays high from edge N+1 of the first write until the end of the last stop bit.
- fifo_empty and fifo_full are updated in the same cycle as count, registered from the next count.

Decomposition:
- Shared package uart_pkg holds:
  - constants UART_DATA_BITS=8, UART_STOP_BITS=1, UART_IDLE_LEVEL=1'b1;
  - the serializer state encoding (IDLE, START, DATA, STOP), so the receiver can reuse bit-timing constants.
- One sub-module, sync_fifo:
  - parameterized width and depth;
  - ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, full, empty, count;
  - rd_data is valid in the cycle rd_en is asserted (first-word fall-through).
- uart_tx_fifo instantiates sync_fifo and contains the baud counter and serializer state machine.

Test Plan:
All scenarios use sys_clk_freq=1000000 and baud_rate=100000 (CLKS_PER_BIT=10), fifo_depth=4 unless stated.
- Reset idle: hold rst_n=0 for 5 cycles, then release. Required: tx=1, fifo_empty=1, is_transmitting=0 for 50 cycles with no stimulus.
- Single frame: transmit 0xA5 once. Required:
  - tx low 2 edges later;
  - bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles;
  - is_transmitting falls at cycle 100 after the frame start.
- Back-to-back: transmit 0x00, 0xFF, 0x55 on consecutive cycles. Required: three contiguous 100-cycle frames with no idle cycle between stop and start; fifo_empty=1 after the first stop of the last frame.
- Overflow: 6 consecutive writes 0x01..0x06 with the line idle. Required:
  - 0x01 is popped;
  - 0x02..0x05 fill the queue, so fifo_full=1;
  - 0x06 is dropped with a single overflow pulse;
  - the line carries 0x01..0x05 only.
- Reset mid-frame: assert rst_n=0 during bit 3 of 0x3C with 2 bytes queued. Required: tx=1 immediately and no further frames after release.
- Wrap-around: 20 bytes written in bursts of 3, each burst spaced so it never fills the queue. Required: all 20 appear in order on tx, and overflow never pulses.
